regfile_writeback_arbiter: RTL and testbench

//   Writer side of the 32x32 register file write port. Merges results from two producers
//   (ALU and load unit) into the single WritePort/WriteData/WriteEnable interface.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/wb_fifo.sv | 68 ++++++
 rtl/regfile_writeback_arbiter.sv | 140 ++++++++++++++
 tb/tb_regfile_writeback_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and types for the register file writeback path
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } src_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small per-source writeback FIFO exposing per-entry destination registers
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_push,
  input  logic [AW-1:0]             i_rd,
  input  logic [DW-1:0]             i_data,
  input  logic                      i_pop,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [AW-1:0]             o_head_rd,
  output logic [DW-1:0]             o_head_data,
  output logic [DEPTH-1:0]          o_valid,
  output logic [DEPTH-1:0][AW-1:0]  o_rd_vec
);

  localparam int PW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0]                r_wptr;
  logic [PW:0]                r_rptr;
  logic [DEPTH-1:0][AW-1:0]   r_rd;
  logic [DEPTH-1:0][DW-1:0]   r_data;
  logic [PW:0]                w_count;
  logic                       w_do_push;
  logic                       w_do_pop;

  assign o_full      = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign o_empty     = (r_wptr == r_rptr);
  assign w_do_push   = i_push && !o_full;
  assign w_do_pop    = i_pop && !o_empty;
  assign w_count     = r_wptr - r_rptr;
  assign o_head_rd   = r_rd[r_rptr[PW-1:0]];
  assign o_head_data = r_data[r_rptr[PW-1:0]];
  assign o_rd_vec    = r_rd;

  // Pointer update; a push and a pop in the same cycle both take effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Entry storage; contents are qualified by the pointers so they need no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_rd[r_wptr[PW-1:0]]   <= i_rd;
      r_data[r_wptr[PW-1:0]] <= i_data;
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    o_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_valid[i] = ({1'b0, PW'(i) - r_rptr[PW-1:0]} < w_count);
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// rtl/regfile_writeback_arbiter.sv - round-robin merge of ALU and load results onto the register file write port
module regfile_writeback_arbiter #(
  parameter int XLEN       = regfile_pkg::XLEN,
  parameter int REG_ADDR_W = regfile_pkg::REG_ADDR_W,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  AluValid,
  input  logic [REG_ADDR_W-1:0] AluRd,
  input  logic [XLEN-1:0]       AluData,
  output logic                  AluReady,
  input  logic                  LdValid,
  input  logic [REG_ADDR_W-1:0] LdRd,
  input  logic [XLEN-1:0]       LdData,
  output logic                  LdReady,
  output logic [REG_ADDR_W-1:0] WritePort,
  output logic [XLEN-1:0]       WriteData,
  output logic                  WriteEnable,
  input  logic [REG_ADDR_W-1:0] QueryA,
  input  logic [REG_ADDR_W-1:0] QueryB,
  output logic                  PendingA,
  output logic                  PendingB
);

  import regfile_pkg::*;

  logic                             w_alu_full;
  logic                             w_alu_empty;
  logic [REG_ADDR_W-1:0]            w_alu_head_rd;
  logic [XLEN-1:0]                  w_alu_head_data;
  logic [DEPTH-1:0]                 w_alu_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] w_alu_rd_vec;

  logic                             w_ld_full;
  logic                             w_ld_empty;
  logic [REG_ADDR_W-1:0]            w_ld_head_rd;
  logic [XLEN-1:0]                  w_ld_head_data;
  logic [DEPTH-1:0]                 w_ld_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] w_ld_rd_vec;

  logic                             w_grant_alu;
  logic                             w_grant_ld;
  logic [REG_ADDR_W-1:0]            w_sel_rd;
  logic [XLEN-1:0]                  w_sel_data;

  logic [REG_ADDR_W-1:0]            r_port;
  logic [XLEN-1:0]                  r_data;
  logic                             r_we;
  src_t                             r_last_grant;

  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign AluReady = !w_alu_full;
  assign LdReady  = !w_ld_full;

  wb_fifo #(.DEPTH(DEPTH), .AW(REG_ADDR_W), .DW(XLEN)) u_alu_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (AluValid),
    .i_rd        (AluRd),
    .i_data      (AluData),
    .i_pop       (w_grant_alu),
    .o_full      (w_alu_full),
    .o_empty     (w_alu_empty),
    .o_head_rd   (w_alu_head_rd),
    .o_head_data (w_alu_head_data),
    .o_valid     (w_alu_valid),
    .o_rd_vec    (w_alu_rd_vec)
  );

  wb_fifo #(.DEPTH(DEPTH), .AW(REG_ADDR_W), .DW(XLEN)) u_ld_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (LdValid),
    .i_rd        (LdRd),
    .i_data      (LdData),
    .i_pop       (w_grant_ld),
    .o_full      (w_ld_full),
    .o_empty     (w_ld_empty),
    .o_head_rd   (w_ld_head_rd),
    .o_head_data (w_ld_head_data),
    .o_valid     (w_ld_valid),
    .o_rd_vec    (w_ld_rd_vec)
  );

  // Round-robin grant: a lone requester always wins, on a tie the source not granted last wins.
  always_comb begin
    w_grant_alu = 1'b0;
    w_grant_ld  = 1'b0;
    if (!w_alu_empty && !w_ld_empty) begin
      if (r_last_grant == SRC_LD) w_grant_alu = 1'b1;
      else                        w_grant_ld  = 1'b1;
    end else if (!w_alu_empty) begin
      w_grant_alu = 1'b1;
    end else if (!w_ld_empty) begin
      w_grant_ld = 1'b1;
    end
    w_sel_rd   = w_grant_alu ? w_alu_head_rd   : w_ld_head_rd;
    w_sel_data = w_grant_alu ? w_alu_head_data : w_ld_head_data;
  end

  // Output registers; rd==0 entries are consumed and count as a grant but never write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_port       <= '0;
      r_data       <= '0;
      r_we         <= 1'b0;
      r_last_grant <= SRC_LD;
    end else if (w_grant_alu || w_grant_ld) begin
      r_port       <= w_sel_rd;
      r_data       <= w_sel_data;
      r_we         <= (w_sel_rd != '0);
      r_last_grant <= w_grant_alu ? SRC_ALU : SRC_LD;
    end else begin
      r_we <= 1'b0;
    end
  end

  assign WritePort   = r_port;
  assign WriteData   = r_data;
  assign WriteEnable = r_we;

  // A register is pending if any queued entry or the in-flight write targets it; x0 never is.
  function automatic logic f_pending(input logic [REG_ADDR_W-1:0] q);
    logic hit;
    hit = r_we && (r_port == q);
    for (int i = 0; i < DEPTH; i++) begin
      if (w_alu_valid[i] && (w_alu_rd_vec[i] == q)) hit = 1'b1;
      if (w_ld_valid[i]  && (w_ld_rd_vec[i]  == q)) hit = 1'b1;
    end
    return (q != '0) && hit;
  endfunction

  // Hazard flags for decode, purely from registered state and the query addresses.
  always_comb begin
    PendingA = f_pending(QueryA);
    PendingB = f_pending(QueryB);
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// tb/tb_regfile_writeback_arbiter.sv - directed self-checking bench for the writeback arbiter
module tb_regfile_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        AluValid, LdValid;
  logic [4:0]  AluRd, LdRd, QueryA, QueryB;
  logic [31:0] AluData, LdData;
  logic        AluReady, LdReady, WriteEnable, PendingA, PendingB;
  logic [4:0]  WritePort;
  logic [31:0] WriteData;

  int n_vec = 0;
  int n_err = 0;

  logic [4:0]  mon_rd[$];
  logic [31:0] mon_data[$];

  regfile_writeback_arbiter #(.XLEN(32), .REG_ADDR_W(5), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .AluValid(AluValid), .AluRd(AluRd), .AluData(AluData), .AluReady(AluReady),
    .LdValid(LdValid), .LdRd(LdRd), .LdData(LdData), .LdReady(LdReady),
    .WritePort(WritePort), .WriteData(WriteData), .WriteEnable(WriteEnable),
    .QueryA(QueryA), .QueryB(QueryB), .PendingA(PendingA), .PendingB(PendingB)
  );

  always #5 clk = ~clk;

  // Record every register file write as it would be committed.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && WriteEnable === 1'b1) begin
      mon_rd.push_back(WritePort);
      mon_data.push_back(WriteData);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    AluValid = 1'b0; LdValid = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    mon_rd.delete(); mon_data.delete();
  endtask

  task automatic test_reset;
    AluValid = 1'b0; LdValid = 1'b0; AluRd = '0; LdRd = '0; AluData = '0; LdData = '0;
    QueryA = 5'd0; QueryB = 5'd3;
    rst_n = 1'b0;
    tick;
    n_vec++; if (WriteEnable !== 1'b0) begin n_err++; $display("FAIL reset_we: got %0b want 0", WriteEnable); end
    n_vec++; if (WritePort !== 5'd0) begin n_err++; $display("FAIL reset_port: got %0d want 0", WritePort); end
    n_vec++; if (WriteData !== 32'd0) begin n_err++; $display("FAIL reset_data: got %0h want 0", WriteData); end
    n_vec++; if (AluReady !== 1'b1 || LdReady !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b%0b want 11", AluReady, LdReady); end
    n_vec++; if (PendingA !== 1'b0 || PendingB !== 1'b0) begin n_err++; $display("FAIL reset_pending: got %0b%0b want 00", PendingA, PendingB); end
    tick;
    rst_n = 1'b1;
    mon_rd.delete(); mon_data.delete();
  endtask

  task automatic test_single;
    AluValid = 1'b1; AluRd = 5'd5; AluData = 32'hDEADBEEF; QueryA = 5'd5; QueryB = 5'd6;
    #1;
    n_vec++; if (PendingA !== 1'b0) begin n_err++; $display("FAIL single_pend_preaccept: got %0b want 0", PendingA); end
    tick;
    AluValid = 1'b0;
    #1;
    n_vec++; if (PendingA !== 1'b1) begin n_err++; $display("FAIL single_pend_queued: got %0b want 1", PendingA); end
    n_vec++; if (WriteEnable !== 1'b0) begin n_err++; $display("FAIL single_we_early: got %0b want 0", WriteEnable); end
    tick;
    n_vec++; if (WriteEnable !== 1'b1) begin n_err++; $display("FAIL single_we: got %0b want 1", WriteEnable); end
    n_vec++; if (WritePort !== 5'd5) begin n_err++; $display("FAIL single_port: got %0d want 5", WritePort); end
    n_vec++; if (WriteData !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data: got %0h want deadbeef", WriteData); end
    n_vec++; if (PendingA !== 1'b1 || PendingB !== 1'b0) begin n_err++; $display("FAIL single_pend_flight: got %0b%0b want 10", PendingA, PendingB); end
    tick;
    n_vec++; if (WriteEnable !== 1'b0) begin n_err++; $display("FAIL single_we_drop: got %0b want 0", WriteEnable); end
    n_vec++; if (WritePort !== 5'd5) begin n_err++; $display("FAIL single_port_hold: got %0d want 5", WritePort); end
    n_vec++; if (PendingA !== 1'b0) begin n_err++; $display("FAIL single_pend_done: got %0b want 0", PendingA); end
    tick;
    n_vec++; if (mon_rd.size() !== 1) begin n_err++; $display("FAIL single_count: got %0d want 1", mon_rd.size()); end
  endtask

  task automatic test_rd_zero;
    mon_rd.delete(); mon_data.delete();
    AluValid = 1'b1; AluRd = 5'd0; AluData = 32'h1234; QueryA = 5'd0;
    #1;
    n_vec++; if (PendingA !== 1'b0) begin n_err++; $display("FAIL rd0_pend0: got %0b want 0", PendingA); end
    tick;
    AluValid = 1'b0;
    #1;
    n_vec++; if (PendingA !== 1'b0 || WriteEnable !== 1'b0) begin n_err++; $display("FAIL rd0_pend1: got pend %0b we %0b want 0 0", PendingA, WriteEnable); end
    tick;
    n_vec++; if (WriteEnable !== 1'b0) begin n_err++; $display("FAIL rd0_we: got %0b want 0", WriteEnable); end
    n_vec++; if (WritePort !== 5'd0 || WriteData !== 32'h1234) begin n_err++; $display("FAIL rd0_regs: got %0d/%0h want 0/1234", WritePort, WriteData); end
    n_vec++; if (PendingA !== 1'b0) begin n_err++; $display("FAIL rd0_pend2: got %0b want 0", PendingA); end
    tick;
    n_vec++; if (mon_rd.size() !== 0) begin n_err++; $display("FAIL rd0_writes: got %0d want 0", mon_rd.size()); end
  endtask

  task automatic test_pending_two;
    apply_reset;
    LdValid = 1'b1; LdRd = 5'd9; LdData = 32'h0900_0001; QueryA = 5'd9; QueryB = 5'd10;
    #1;
    n_vec++; if (PendingA !== 1'b0) begin n_err++; $display("FAIL pend9_pre: got %0b want 0", PendingA); end
    tick;
    LdData = 32'h0900_0002;
    #1;
    n_vec++; if (PendingA !== 1'b1) begin n_err++; $display("FAIL pend9_fifo: got %0b want 1", PendingA); end
    tick;
    LdValid = 1'b0;
    #1;
    n_vec++; if (PendingA !== 1'b1 || WriteEnable !== 1'b1 || WriteData !== 32'h0900_0001) begin n_err++; $display("FAIL pend9_first: got pend %0b we %0b data %0h want 1 1 9000001", PendingA, WriteEnable, WriteData); end
    tick;
    n_vec++; if (PendingA !== 1'b1 || WriteEnable !== 1'b1 || WriteData !== 32'h0900_0002) begin n_err++; $display("FAIL pend9_second: got pend %0b we %0b data %0h want 1 1 9000002", PendingA, WriteEnable, WriteData); end
    tick;
    n_vec++; if (PendingA !== 1'b0 || PendingB !== 1'b0 || WriteEnable !== 1'b0) begin n_err++; $display("FAIL pend9_done: got %0b%0b we %0b want 00 0", PendingA, PendingB, WriteEnable); end
  endtask

  task automatic test_back_to_back;
    int ai, li, cyc, alu_stall, ld_stall;
    logic alu_acc, ld_acc;
    apply_reset;
    ai = 0; li = 0; cyc = 0; alu_stall = 0; ld_stall = 0;
    while ((ai < 4 || li < 4) && cyc < 50) begin
      AluValid = (ai < 4); AluRd = 5'(ai + 1);  AluData = 32'hA000_0001 + 32'(ai);
      LdValid  = (li < 4); LdRd  = 5'(li + 17); LdData  = 32'hB000_0011 + 32'(li);
      #1;
      alu_acc = AluValid && AluReady;
      ld_acc  = LdValid && LdReady;
      if (AluValid && !AluReady) alu_stall++;
      if (LdValid && !LdReady) ld_stall++;
      tick;
      if (alu_acc) ai++;
      if (ld_acc) li++;
      cyc++;
    end
    AluValid = 1'b0; LdValid = 1'b0;
    repeat (6) tick;
    n_vec++; if (cyc !== 6) begin n_err++; $display("FAIL b2b_cycles: got %0d want 6", cyc); end
    n_vec++; if (alu_stall !== 1) begin n_err++; $display("FAIL b2b_alu_stall: got %0d want 1", alu_stall); end
    n_vec++; if (ld_stall !== 2) begin n_err++; $display("FAIL b2b_ld_stall: got %0d want 2", ld_stall); end
    n_vec++; if (mon_rd.size() !== 8) begin n_err++; $display("FAIL b2b_count: got %0d want 8", mon_rd.size()); end
    for (int k = 0; k < 8 && k < mon_rd.size(); k++) begin
      logic [4:0]  exp_rd;
      logic [31:0] exp_data;
      exp_rd   = (k % 2 == 0) ? 5'(k / 2 + 1) : 5'(k / 2 + 17);
      exp_data = (k % 2 == 0) ? 32'hA000_0001 + 32'(k / 2) : 32'hB000_0011 + 32'(k / 2);
      n_vec++;
      if (mon_rd[k] !== exp_rd || mon_data[k] !== exp_data) begin
        n_err++; $display("FAIL b2b_order[%0d]: got %0d/%0h want %0d/%0h", k, mon_rd[k], mon_data[k], exp_rd, exp_data);
      end
    end
  endtask

  task automatic test_async_reset;
    apply_reset;
    AluValid = 1'b1; AluRd = 5'd21; AluData = 32'hC000_0021;
    LdValid  = 1'b1; LdRd  = 5'd11; LdData  = 32'hC000_0011;
    tick;
    AluRd = 5'd22; AluData = 32'hC000_0022;
    LdRd  = 5'd12; LdData  = 32'hC000_0012;
    tick;
    AluValid = 1'b0; LdValid = 1'b0; QueryA = 5'd12; QueryB = 5'd22;
    #1;
    n_vec++; if (PendingA !== 1'b1 || PendingB !== 1'b1 || WriteEnable !== 1'b1 || WritePort !== 5'd21) begin n_err++; $display("FAIL arst_pre: got %0b%0b we %0b port %0d want 11 1 21", PendingA, PendingB, WriteEnable, WritePort); end
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++; if (WriteEnable !== 1'b0 || WritePort !== 5'd0 || WriteData !== 32'd0) begin n_err++; $display("FAIL arst_outputs: got we %0b port %0d data %0h want 0 0 0", WriteEnable, WritePort, WriteData); end
    n_vec++; if (AluReady !== 1'b1 || LdReady !== 1'b1 || PendingA !== 1'b0 || PendingB !== 1'b0) begin n_err++; $display("FAIL arst_state: got rdy %0b%0b pend %0b%0b want 11 00", AluReady, LdReady, PendingA, PendingB); end
    tick;
    rst_n = 1'b1;
    mon_rd.delete(); mon_data.delete();
    repeat (4) tick;
    n_vec++; if (mon_rd.size() !== 0 || WriteEnable !== 1'b0) begin n_err++; $display("FAIL arst_stale: got %0d writes we %0b want 0 0", mon_rd.size(), WriteEnable); end
    n_vec++; if (AluReady !== 1'b1 || LdReady !== 1'b1) begin n_err++; $display("FAIL arst_ready: got %0b%0b want 11", AluReady, LdReady); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_rd_zero;
    test_pending_two;
    test_back_to_back;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
